// File: rtl/core_pkg.sv
// Shared decode constants: immediate-source encodings used by the control
// unit and the immediate pipeline, plus the pipeline FSM state type.
package core_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;
    localparam logic [2:0] IMM_Z = 3'b101;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction from a 32-bit instruction word,
// extended to XLEN. Reserved source encodings yield zero and flag illegal.
module imm_decode
    import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     instr_i,
    input  logic [2:0]      imm_src_i,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    logic [31:0] imm32;
    logic        sign;
    logic        unused_opcode;

    assign sign          = instr_i[31];
    assign unused_opcode = ^instr_i[6:0];

    // Every format is first built as a 32-bit signed value; zimm has bit 31
    // clear, so one sign extension to XLEN below is correct for all of them.
    always_comb begin
        imm32     = '0;
        illegal_o = 1'b0;
        case (imm_src_i)
            IMM_I:   imm32 = {{20{sign}}, instr_i[31:20]};
            IMM_S:   imm32 = {{20{sign}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm32 = {{19{sign}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:   imm32 = {instr_i[31:12], 12'b0};
            IMM_J:   imm32 = {{11{sign}}, instr_i[31], instr_i[19:12],
                              instr_i[20], instr_i[30:21], 1'b0};
            IMM_Z:   imm32 = {27'b0, instr_i[19:15]};
            default: illegal_o = 1'b1;
        endcase
    end

    assign imm_o = XLEN'(signed'(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate-generation stage between decode and ID/EX, with an
// optional two-entry skid buffer so downstream stalls never reach decode combinationally.
module imm_gen_pipe
    import core_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int TAG_W   = 5,
    parameter int SKID_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [1:0]       state_o
);

    localparam int ENTRY_W = XLEN + TAG_W + 1;

    logic [XLEN-1:0]    dec_imm;
    logic               dec_illegal;
    logic [ENTRY_W-1:0] in_entry;

    logic [ENTRY_W-1:0] main_q, main_d;
    logic [ENTRY_W-1:0] skid_q, skid_d;
    pipe_state_e        state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    logic               accept;
    logic               pop;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr_i   (in_instr),
        .imm_src_i (in_imm_src),
        .imm_o     (dec_imm),
        .illegal_o (dec_illegal)
    );

    assign in_entry = {dec_illegal, in_tag, dec_imm};

    // Handshake: a beat moves on a rising edge only when valid and ready are
    // both high; out_valid and its payload hold until popped, and flush kills
    // held entries and any same-cycle input regardless of either ready.
    assign in_ready = (SKID_EN != 0) ? in_ready_q : (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready & ~flush;
    assign pop      = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_FULL;
                        main_d  = in_entry;
                    end
                end
                ST_FULL: begin
                    if (accept && pop) begin
                        main_d = in_entry;
                    end else if (accept) begin
                        // Only reachable with the skid buffer: without it an
                        // accept while full always coincides with a pop.
                        state_d = ST_SKID;
                        skid_d  = in_entry;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (pop) begin
                        state_d = ST_FULL;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_SKID);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign out_valid                       = out_valid_q;
    assign {out_illegal, out_tag, out_imm} = main_q;
    assign state_o                         = state_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 64-bit skid instance (a) and a 32-bit no-skid
// instance (b) share stimulus; each has its own expected queue.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_imm_src;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        ready_a, valid_a, ill_a;
    logic [63:0] imm_a;
    logic [4:0]  tag_a;
    logic [1:0]  state_a;

    logic        ready_b, valid_b, ill_b;
    logic [31:0] imm_b;
    logic [4:0]  tag_b;
    logic [1:0]  state_b;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [69:0] exp_a_q[$];
    logic [69:0] exp_b_q[$];
    logic [4:0]  got_tags_a[$];
    logic        hold_a = 1'b0;
    logic [69:0] held_a = '0;

    imm_gen_pipe #(.XLEN(64), .TAG_W(5), .SKID_EN(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(ready_a), .in_instr(in_instr),
        .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(valid_a), .out_ready(out_ready), .out_imm(imm_a),
        .out_tag(tag_a), .out_illegal(ill_a), .state_o(state_a)
    );

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .SKID_EN(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(ready_b), .in_instr(in_instr),
        .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(valid_b), .out_ready(out_ready), .out_imm(imm_b),
        .out_tag(tag_b), .out_illegal(ill_b), .state_o(state_b)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference immediate at 64 bits: {illegal, imm64}
    function automatic logic [64:0] model_imm(input logic [31:0] ins, input logic [2:0] src);
        logic [63:0] v;
        logic        ill;
        v   = '0;
        ill = 1'b0;
        case (src)
            3'd0: v = {{52{ins[31]}}, ins[31:20]};
            3'd1: v = {{52{ins[31]}}, ins[31:25], ins[11:7]};
            3'd2: v = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            3'd3: v = {{32{ins[31]}}, ins[31:12], 12'b0};
            3'd4: v = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            3'd5: v = {59'b0, ins[19:15]};
            default: ill = 1'b1;
        endcase
        return {ill, v};
    endfunction

    // ---------------- scoreboard monitor ----------------
    // Inputs only change just after a rising edge, so the falling edge sees
    // exactly the handshake values that the next rising edge will act on.
    always @(negedge clk) begin
        logic [69:0] e;
        logic [64:0] m;
        if (!rst_n || flush) begin
            exp_a_q.delete();
            exp_b_q.delete();
            hold_a = 1'b0;
        end else begin
            if (hold_a) begin
                total_cnt++;
                if (!valid_a || {ill_a, tag_a, imm_a} !== held_a)
                    $display("FAIL hold_a: got v=%0b %h required v=1 %h", valid_a, {ill_a, tag_a, imm_a}, held_a);
                else
                    pass_cnt++;
            end
            hold_a = valid_a && !out_ready;
            held_a = {ill_a, tag_a, imm_a};
            if (valid_a && out_ready) begin
                total_cnt++;
                got_tags_a.push_back(tag_a);
                if (exp_a_q.size() == 0) begin
                    $display("FAIL sb_a: unexpected output %h", {ill_a, tag_a, imm_a});
                end else begin
                    e = exp_a_q.pop_front();
                    if ({ill_a, tag_a, imm_a} !== e)
                        $display("FAIL sb_a: got %h required %h", {ill_a, tag_a, imm_a}, e);
                    else
                        pass_cnt++;
                end
            end
            if (valid_b && out_ready) begin
                total_cnt++;
                if (exp_b_q.size() == 0) begin
                    $display("FAIL sb_b: unexpected output %h", {ill_b, tag_b, imm_b});
                end else begin
                    e = exp_b_q.pop_front();
                    if ({ill_b, tag_b, imm_b} !== {e[69:64], e[31:0]})
                        $display("FAIL sb_b: got %h required %h", {ill_b, tag_b, imm_b}, {e[69:64], e[31:0]});
                    else
                        pass_cnt++;
                end
            end
            m = model_imm(in_instr, in_imm_src);
            if (in_valid && ready_a) exp_a_q.push_back({m[64], in_tag, m[63:0]});
            if (in_valid && ready_b) exp_b_q.push_back({m[64], in_tag, m[63:0]});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] src, input logic [4:0] tag);
        in_valid   = v;
        in_instr   = ins;
        in_imm_src = src;
        in_tag     = tag;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if ({valid_a, valid_b} !== 2'b00) $display("FAIL reset_valid: got %b required 00", {valid_a, valid_b});
        else pass_cnt++;
        total_cnt++;
        if ({ready_a, ready_b} !== 2'b11) $display("FAIL reset_ready: got %b required 11", {ready_a, ready_b});
        else pass_cnt++;
        total_cnt++;
        if ({ill_a, tag_a, imm_a} !== 70'h0) $display("FAIL reset_data_a: got %h required 0", {ill_a, tag_a, imm_a});
        else pass_cnt++;
        total_cnt++;
        if ({ill_b, tag_b, imm_b} !== 38'h0) $display("FAIL reset_data_b: got %h required 0", {ill_b, tag_b, imm_b});
        else pass_cnt++;
        total_cnt++;
        if (state_a !== 2'd0) $display("FAIL reset_state: got %0d required 0", state_a);
        else pass_cnt++;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(1'b1, 32'hFFF00093, 3'd0, 5'd3);
        tick();
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        total_cnt++;
        if ({valid_a, valid_b} !== 2'b11) $display("FAIL single_latency: got %b required 11", {valid_a, valid_b});
        else pass_cnt++;
        total_cnt++;
        if (imm_a !== 64'hFFFF_FFFF_FFFF_FFFF || imm_b !== 32'hFFFF_FFFF || ill_b !== 1'b0)
            $display("FAIL single_imm: got %h/%h ill=%b required ffffffffffffffff/ffffffff ill=0", imm_a, imm_b, ill_b);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({valid_a, valid_b} !== 2'b00) $display("FAIL single_drop: got %b required 00", {valid_a, valid_b});
        else pass_cnt++;
    endtask

    task automatic test_decode();
        logic [31:0] t_ins [11];
        logic [2:0]  t_src [11];
        logic [63:0] t_imm [11];
        logic        t_ill [11];
        logic [63:0] x64;
        t_ins = '{32'hFFF00093, 32'h80000FA3, 32'hFE000EE3, 32'h800002B7, 32'h0000006F,
                  32'h0080006F, 32'hFFFFF06F, 32'h800002B7, 32'h000F8073, 32'hFFFFFFFF, 32'hFFFFFFFF};
        t_src = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
        t_imm = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFF81F, 64'hFFFFFFFFFFFFFFFC,
                  64'hFFFFFFFF80000000, 64'h0, 64'h8, 64'hFFFFFFFFFFFFFFFE, 64'h0, 64'h1F, 64'h0, 64'h0};
        t_ill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, t_ins[i], t_src[i], 5'(i + 8));
            tick();
            x64 = t_imm[i];
            total_cnt++;
            if (valid_a !== 1'b1 || imm_a !== x64 || ill_a !== t_ill[i] || tag_a !== 5'(i + 8))
                $display("FAIL decode_a[%0d]: got v=%b %h ill=%b tag=%0d required v=1 %h ill=%b tag=%0d",
                         i, valid_a, imm_a, ill_a, tag_a, x64, t_ill[i], i + 8);
            else pass_cnt++;
            total_cnt++;
            if (valid_b !== 1'b1 || imm_b !== x64[31:0] || ill_b !== t_ill[i])
                $display("FAIL decode_b[%0d]: got v=%b %h ill=%b required v=1 %h ill=%b",
                         i, valid_b, imm_b, ill_b, x64[31:0], t_ill[i]);
            else pass_cnt++;
        end
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        tick();
    endtask

    task automatic test_back_to_back();
        int          idx = 0;
        int          last_acc = -1;
        logic        acc;
        logic [31:0] ins [6];
        logic [2:0]  src [6];
        for (int i = 0; i < 6; i++) begin
            ins[i] = $urandom;
            src[i] = 3'($urandom_range(0, 7));
        end
        got_tags_a.delete();
        for (int cyc = 0; cyc < 15; cyc++) begin
            out_ready = !(cyc inside {1, 2, 3});
            if (idx < 6) drive(1'b1, ins[idx], src[idx], 5'(idx + 1));
            else         drive(1'b0, 32'h0, 3'd0, 5'd0);
            acc = in_valid && ready_a;
            tick();
            if (acc) begin
                idx++;
                last_acc = cyc;
            end
            if (cyc < 8) begin
                total_cnt++;
                if (ready_a !== !(cyc inside {1, 2, 3}))
                    $display("FAIL b2b_in_ready[c%0d]: got %b required %b", cyc, ready_a, !(cyc inside {1, 2, 3}));
                else pass_cnt++;
            end
        end
        out_ready = 1'b1;
        total_cnt++;
        if (last_acc !== 8) $display("FAIL b2b_throughput: last accept cycle %0d required 8", last_acc);
        else pass_cnt++;
        total_cnt++;
        if (got_tags_a.size() !== 6) $display("FAIL b2b_count: got %0d entries required 6", got_tags_a.size());
        else pass_cnt++;
        for (int i = 0; i < 6 && i < got_tags_a.size(); i++) begin
            total_cnt++;
            if (got_tags_a[i] !== 5'(i + 1)) $display("FAIL b2b_order[%0d]: got tag %0d required %0d", i, got_tags_a[i], i + 1);
            else pass_cnt++;
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'h00A00093, 3'd0, 5'd10);
        tick();
        drive(1'b1, 32'h00B00093, 3'd0, 5'd11);
        tick();
        total_cnt++;
        if (state_a !== 2'd2 || ready_a !== 1'b0) $display("FAIL flush_pre_skid: got state=%0d rdy=%b required 2 0", state_a, ready_a);
        else pass_cnt++;
        flush = 1'b1;
        drive(1'b1, 32'hFFF00093, 3'd0, 5'd31);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        total_cnt++;
        if ({valid_a, ready_a, valid_b} !== 3'b010) $display("FAIL flush_skid: got va/ra/vb=%b required 010", {valid_a, ready_a, valid_b});
        else pass_cnt++;
        out_ready = 1'b1;
        drive(1'b1, 32'h00C00093, 3'd0, 5'd12);
        tick();
        flush = 1'b1;
        drive(1'b1, 32'h12345037, 3'd3, 5'd30);
        total_cnt++;
        if ({ready_a, ready_b} !== 2'b11) $display("FAIL flush_ready_high: got %b required 11", {ready_a, ready_b});
        else pass_cnt++;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        repeat (3) begin
            total_cnt++;
            if ({valid_a, valid_b} !== 2'b00) $display("FAIL flush_no_output: got %b required 00", {valid_a, valid_b});
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        drive(1'b1, 32'h00100093, 3'd0, 5'd1);
        tick();
        drive(1'b1, 32'h00200093, 3'd0, 5'd2);
        tick();
        total_cnt++;
        if (valid_a !== 1'b1) $display("FAIL rst_mid_pre: got %b required 1", valid_a);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({valid_a, valid_b, ready_a} !== 3'b001) $display("FAIL rst_mid_async: got va/vb/ra=%b required 001", {valid_a, valid_b, ready_a});
        else pass_cnt++;
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        tick();
        rst_n = 1'b1;
        drive(1'b1, 32'h80000FA3, 3'd1, 5'd7);
        tick();
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        total_cnt++;
        if (valid_a !== 1'b1 || tag_a !== 5'd7 || imm_a !== 64'hFFFFFFFFFFFFF81F)
            $display("FAIL rst_mid_latency: got v=%b tag=%0d %h required v=1 tag=7 fffffffffffff81f", valid_a, tag_a, imm_a);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (valid_a !== 1'b0) $display("FAIL rst_mid_drain: got %b required 0", valid_a);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic acc;
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        for (int n = 0; n < 400; n++) begin
            acc = in_valid && ready_a;
            tick();
            if (acc || !in_valid)
                drive($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        out_ready = 1'b1;
        repeat (5) tick();
        total_cnt++;
        if (exp_a_q.size() != 0 || exp_b_q.size() != 0)
            $display("FAIL random_drain: queues a=%0d b=%0d required 0 0", exp_a_q.size(), exp_b_q.size());
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_decode();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
